// File: rtl/pulp_ls_pkg.sv
// Shared types for the output level shifter with isolation sequencer.
// The state encoding is visible to the power manager through state_o.
package pulp_ls_pkg;

  localparam int unsigned STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ACTIVE   = 2'd0,
    CLAMP    = 2'd1,
    ISOLATED = 2'd2,
    RELEASE  = 2'd3
  } iso_state_e;

endpackage

// File: rtl/pulp_ls_settle_cnt.sv
// Settle-time counter shared by the CLAMP and RELEASE phases.
// It saturates at SETTLE_CYCLES-1, where done is raised.
module pulp_ls_settle_cnt #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  // count settle cycles; clear has priority so every phase starts from zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !done) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/pulp_level_shifter_out_iso.sv
// Output level shifter with clamp/settle/acknowledge isolation sequencing.
// Define PULP_LS_OUT_ISO_REG_EN to register out_o (ack delayed to match).
module pulp_level_shifter_out_iso
  import pulp_ls_pkg::*;
#(
  parameter int unsigned           WIDTH         = 32,
  parameter logic [WIDTH-1:0]      CLAMP_VAL     = '0,
  parameter int unsigned           SETTLE_CYCLES = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               iso_req_i,
  output logic               iso_ack_o,
  output logic [STATE_W-1:0] state_o,
  input  logic [WIDTH-1:0]   in_i,
  output logic [WIDTH-1:0]   out_o
);

  iso_state_e       state;
  iso_state_e       state_nxt;
  logic             cnt_clr;
  logic             cnt_en;
  logic             cnt_done;
  logic             ack;
  logic [WIDTH-1:0] mux_out;

  pulp_ls_settle_cnt #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) i_settle_cnt (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .done  (cnt_done)
  );

  // next-state logic; a change of request direction always wins over settle completion
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b1;
    cnt_en    = 1'b0;
    case (state)
      ACTIVE: begin
        if (iso_req_i) state_nxt = CLAMP;
        else           state_nxt = ACTIVE;
      end
      CLAMP: begin
        if (!iso_req_i) begin
          state_nxt = RELEASE;
        end else if (cnt_done) begin
          state_nxt = ISOLATED;
        end else begin
          state_nxt = CLAMP;
          cnt_clr   = 1'b0;
          cnt_en    = 1'b1;
        end
      end
      ISOLATED: begin
        if (!iso_req_i) state_nxt = RELEASE;
        else            state_nxt = ISOLATED;
      end
      RELEASE: begin
        if (iso_req_i) begin
          state_nxt = CLAMP;
        end else if (cnt_done) begin
          state_nxt = ACTIVE;
        end else begin
          state_nxt = RELEASE;
          cnt_clr   = 1'b0;
          cnt_en    = 1'b1;
        end
      end
      default: state_nxt = ISOLATED;
    endcase
  end

  // sequencer state and registered ack; reset lands in the power-on-safe isolated state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ISOLATED;
      ack   <= 1'b1;
    end else begin
      state <= state_nxt;
      ack   <= (state_nxt == ISOLATED);
    end
  end

  assign mux_out = (state == ACTIVE) ? in_i : CLAMP_VAL;
  assign state_o = state;

`ifdef PULP_LS_OUT_ISO_REG_EN
  logic [WIDTH-1:0] out_q;
  logic             ack_q;

  // output register; ack is held back one cycle so it never precedes the clamp
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q <= CLAMP_VAL;
      ack_q <= 1'b1;
    end else begin
      out_q <= mux_out;
      ack_q <= ack;
    end
  end

  assign out_o     = out_q;
  assign iso_ack_o = ack_q;
`else
  assign out_o     = mux_out;
  assign iso_ack_o = ack;
`endif

endmodule

// File: tb/tb_pulp_level_shifter_out_iso.sv
// Randomised bench for pulp_level_shifter_out_iso against a direction/settle-time model,
// with literal checks of reset, clamp, abort, re-request and asynchronous reset.
module tb_pulp_level_shifter_out_iso;

  localparam int          W   = 8;
  localparam logic [7:0]  CV  = 8'hA5;
  localparam int          S   = 4;
`ifdef PULP_LS_OUT_ISO_REG_EN
  localparam int          LAT = 1;
`else
  localparam int          LAT = 0;
`endif
  localparam int          ACK_LAT = S + LAT;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req;
  logic [W-1:0] din;
  logic [W-1:0] dout;
  logic         ack;
  logic [1:0]   st;

  int checks = 0;
  int errors = 0;

  // model: the direction last requested and how long it has been stable
  bit           m_dir;
  int           m_settled;
  logic [W-1:0] m_prev_out;
  bit           m_prev_ack;

  pulp_level_shifter_out_iso #(
    .WIDTH        (W),
    .CLAMP_VAL    (CV),
    .SETTLE_CYCLES(S)
  ) dut (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .iso_req_i(req),
    .iso_ack_o(ack),
    .state_o  (st),
    .in_i     (din),
    .out_o    (dout)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] m_out(input logic [W-1:0] x);
    return (!m_dir && m_settled == S) ? x : CV;
  endfunction

  function automatic bit m_ack();
    return m_dir && (m_settled == S);
  endfunction

  function automatic logic [1:0] m_state();
    if (m_settled == S) return m_dir ? 2'd2 : 2'd0;
    else                return m_dir ? 2'd1 : 2'd3;
  endfunction

  task automatic model_reset();
    m_dir      = 1'b1;
    m_settled  = S;
    m_prev_out = CV;
    m_prev_ack = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // one clock edge: advance the model with the pre-edge inputs, then settle
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      m_prev_out = m_out(din);
      m_prev_ack = m_ack();
      if (req != m_dir) begin
        m_dir     = req;
        m_settled = 0;
      end else if (m_settled < S) begin
        m_settled++;
      end
    end
    #2;
  endtask

  always @(negedge clk) begin
    chk("state", 32'(st), 32'(m_state()));
    chk("ack", 32'(ack), (LAT != 0) ? 32'(m_prev_ack) : 32'(m_ack()));
    chk("out", 32'(dout), (LAT != 0) ? 32'(m_prev_out) : 32'(m_out(din)));
  end

  initial begin
    rst_n = 1'b0;
    req   = 1'b0;
    din   = 8'h3C;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out", 32'(dout), 32'hA5);
    chk("rst_ack", 32'(ack), 32'h1);
    chk("rst_state", 32'(st), 32'h2);

    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();
    for (int i = 0; i < S; i++) begin
      chk("rel_state", 32'(st), 32'h3);
      step();
    end
    chk("act_state", 32'(st), 32'h0);
    repeat (LAT) step();
    chk("act_out", 32'(dout), 32'h3C);
    din = 8'h96;
    repeat (LAT) step();
    #1;
    chk("act_track", 32'(dout), 32'h96);

    // clamp and ack latency
    req = 1'b1;
    step();
    chk("clamp_state", 32'(st), 32'h1);
    chk("ack_early", 32'(ack), 32'h0);
    repeat (LAT) step();
    chk("clamp_out", 32'(dout), 32'hA5);
    for (int i = LAT + 1; i <= ACK_LAT; i++) begin
      step();
      chk("ack_lat", 32'(ack), 32'(i == ACK_LAT));
    end

    // abort after two CLAMP cycles
    req = 1'b0;
    repeat (S + LAT + 2) step();
    chk("back_active", 32'(st), 32'h0);
    req = 1'b1;
    step();
    step();
    req = 1'b0;
    step();
    chk("abort_state", 32'(st), 32'h3);
    for (int i = 0; i < S; i++) begin
      chk("abort_ack", 32'(ack), 32'h0);
      step();
    end
    chk("abort_active", 32'(st), 32'h0);

    // re-request during the second RELEASE cycle
    req = 1'b1;
    repeat (ACK_LAT + 2) step();
    chk("iso_ack", 32'(ack), 32'h1);
    req = 1'b0;
    step();
    step();
    req = 1'b1;
    step();
    chk("rereq_state", 32'(st), 32'h1);
    for (int i = 1; i <= ACK_LAT; i++) begin
      step();
      chk("rereq_ack", 32'(ack), 32'(i == ACK_LAT));
    end

    // asynchronous reset while ACTIVE
    req = 1'b0;
    repeat (S + LAT + 2) step();
    chk("pre_rst_state", 32'(st), 32'h0);
    din = 8'h11;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_out", 32'(dout), 32'hA5);
    chk("async_ack", 32'(ack), 32'h1);
    chk("async_state", 32'(st), 32'h2);
    step();
    step();
    rst_n = 1'b1;

    // random traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      din = 8'($urandom);
      if ($urandom_range(0, 5) == 0) req = ~req;
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        model_reset();
      end else begin
        rst_n = 1'b1;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulp_level_shifter_out_iso.md
# pulp_level_shifter_out_iso

Parametrised multi-bit output level shifter with a built-in isolation sequencer. It is placed on every signal bundle leaving a switchable power domain toward always-on logic. In normal operation it passes `in_i` straight through. On an isolation request it clamps all outputs to a per-bit safe value, waits a programmable settle time, then acknowledges. On release it waits the settle time again before un-clamping.

## Interface
Parameters:
- `WIDTH`, 32: number of shifted channels (≥1).
- `CLAMP_VAL`, `'0`: `[WIDTH-1:0]` per-bit value driven while isolated.
- `SETTLE_CYCLES`, 4: clamp/release settle time in clock cycles (≥1).

Ports:
- `clk_i`  in  1  always-on clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `iso_req_i`  in  1  level isolation request (1 = isolate the source domain).
- `iso_ack_o`  out  1  1 = outputs clamped and settled.
- `state_o`  out  2  current sequencer state, for power-manager debug.
- `in_i`  in  WIDTH  signals from the switchable domain.
- `out_o`  out  WIDTH  shifted/clamped signals to the always-on domain.

## Operation
- Four-phase handshake: requester raises `iso_req_i` and holds it until `iso_ack_o`=1. It lowers the request and holds it low until `iso_ack_o`=0.
- FSM states, encoded in `state_o`:
  - ACTIVE = 0:
    - `out_o` = `in_i`; `iso_ack_o` = 0.
    - `iso_req_i`=1 → CLAMP, counter cleared.
  - CLAMP = 1:
    - `out_o` = `CLAMP_VAL`; `iso_ack_o` = 0.
    - Counter increments each cycle; at `SETTLE_CYCLES`-1 → ISOLATED.
    - `iso_req_i`=0 (abort) → RELEASE, counter cleared.
  - ISOLATED = 2:
    - `out_o` = `CLAMP_VAL`; `iso_ack_o` = 1.
    - `iso_req_i`=0 → RELEASE, counter cleared.
  - RELEASE = 3:
    - `out_o` = `CLAMP_VAL`; `iso_ack_o` = 0.
    - Counter increments each cycle; at `SETTLE_CYCLES`-1 → ACTIVE.
    - `iso_req_i`=1 (re-request) → CLAMP, counter cleared.
- Counter width: `$clog2(SETTLE_CYCLES+1)`. It never wraps, because it is always cleared on state entry.
- `iso_req_i` is treated as synchronous to `clk_i`. Synchronising it is the power manager's job.

## Timing
- Reset state is ISOLATED, which is power-on safe:
  - `out_o` = `CLAMP_VAL`, `iso_ack_o` = 1, `state_o` = 2.
  - Counter = 0.
- If `iso_req_i`=0 at the first edge after reset release, the block enters RELEASE and reaches ACTIVE `SETTLE_CYCLES` cycles later.
- Clamp latency: `iso_req_i` sampled high at edge N → state CLAMP after N → `out_o` clamped from cycle N+1.
- Ack latency: `iso_ack_o` rises `SETTLE_CYCLES` edges after entering CLAMP.
- Release: `iso_req_i` sampled low at edge M → RELEASE → `out_o` follows `in_i` from `SETTLE_CYCLES` edges after M+1. `iso_ack_o` drops after M.
- ACTIVE data path is combinational, with zero latency, unless the output register is compiled in (see Configuration).
- Reset asserted mid-operation forces ISOLATED and the clamp immediately (asynchronously), in any state.

## Configuration
- Macro `PULP_LS_OUT_ISO_REG_EN`.
- Defined:
  - `out_o` is registered. Every mux result takes one extra cycle, data and clamp alike.
  - The register resets to `CLAMP_VAL`.
  - `iso_ack_o` is delayed by one extra cycle, so ack never precedes the registered clamp.
- Undefined: `out_o` is the combinational mux of `in_i`/`CLAMP_VAL` selected by the state register; ack timing is as stated in Timing.

## Structure
- Package `pulp_ls_pkg`: `iso_state_e` enum (ACTIVE/CLAMP/ISOLATED/RELEASE, 2-bit, fixed encodings above) and the `state_o` width constant.
- Sub-module `pulp_ls_settle_cnt`: clear/enable counter with a `done` flag at `SETTLE_CYCLES`-1, parametrised by `SETTLE_CYCLES`, and shared by CLAMP and RELEASE.
- The top level holds the FSM, the output mux and the optional output register.

## Test plan
- Reset with `iso_req_i`=0, `WIDTH`=8, `CLAMP_VAL`=8'hA5, `SETTLE_CYCLES`=4:
  - During reset: `out_o`=A5, `iso_ack_o`=1.
  - After release: state 3 for 4 cycles, then `out_o` tracks `in_i`=8'h3C.
- ACTIVE, `iso_req_i` raised: `out_o`=A5 one cycle later; `iso_ack_o`=1 exactly 4 cycles after CLAMP entry.
- Abort: raise `iso_req_i`, drop it after 2 CLAMP cycles → RELEASE; `iso_ack_o` never rises; ACTIVE 4 cycles later.
- Re-request during RELEASE cycle 2 → CLAMP with counter restarted; ack after 4 more cycles.
- Assert `rst_ni`=0 asynchronously in ACTIVE → `out_o`=A5 before the next clock edge.
- With `PULP_LS_OUT_ISO_REG_EN` defined: in ACTIVE, `in_i` changes appear one cycle later; `iso_ack_o` rises 5 cycles after CLAMP entry.
